// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad event path: FSM states,
// the queued event record and the idle level of the active-low row pins.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HELD,
        REPEAT
    } key_state_t;

    // 5-bit queue entry: key code plus press/auto-repeat flag.
    typedef struct packed {
        logic [3:0] code;
        logic       is_repeat;
    } key_evt_t;

    localparam logic [3:0] ROWS_IDLE = 4'hF;

endpackage

// File: rtl/keypad_evt_fifo.sv
// First-word fall-through FIFO of 5-bit key events. A push to a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is ignored.
module keypad_evt_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [4:0]               push_data,
    input  logic                     pop,
    output logic [4:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE       = (AW + 1)'(1);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_en;
    logic          wr_en;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Storage is undefined after reset, so the head is masked while empty.
    assign head = empty ? 5'd0 : mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and count alone
    // define what is valid, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_event_queue.sv
// Debounces keypad presses, generates press and auto-repeat events and
// queues them for the game logic behind a valid/ready handshake.
module keypad_event_queue
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2000000,
    parameter int SCAN_CYCLES     = 400000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    key_code,
    input  logic [3:0]                    key_row,
    output logic [3:0]                    evt_code,
    output logic                          evt_repeat,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic                          key_held,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CNT = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int RW      = $clog2(SCAN_CYCLES + 1);

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
    localparam logic [RW-1:0] SCAN_LOAD  = RW'(SCAN_CYCLES);

    logic [3:0] row_meta;
    logic [3:0] row_sync;
    logic       any_low;
    logic [RW-1:0] quiet_left;
    logic       pressed;

    key_state_t state;
    logic [CW-1:0] cnt;
    logic [3:0] cand;
    logic       term;
    logic       push;
    key_evt_t   push_evt;
    key_evt_t   head_evt;
    logic       pop;
    logic       full;
    logic       empty;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, which is what makes the two-flop chain a chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= ROWS_IDLE;
            row_sync <= ROWS_IDLE;
        end else begin
            row_meta <= key_row;
            row_sync <= row_meta;
        end
    end

    assign any_low = (row_sync != ROWS_IDLE);

    // Counts down the remaining quiet time instead of up the elapsed time, so
    // the reset value 0 means "released" and no phantom press follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quiet_left <= '0;
        end else if (any_low) begin
            quiet_left <= SCAN_LOAD;
        end else if (quiet_left != '0) begin
            quiet_left <= quiet_left - RW'(1);
        end
    end

    assign pressed = (quiet_left != '0);

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        term = 1'b0;
        case (state)
            DEBOUNCE: term = (cnt == DEB_LAST);
            HELD:     term = (cnt == DELAY_LAST);
            REPEAT:   term = (cnt == RATE_LAST);
            default:  term = 1'b0;
        endcase
    end

    // An event is issued on the terminal count only if neither release nor a
    // code change pre-empts it this cycle.
    assign push               = (state != IDLE) && pressed && (key_code == cand) && term;
    assign push_evt.code      = cand;
    assign push_evt.is_repeat = (state != DEBOUNCE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cand     <= '0;
            key_held <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= DEBOUNCE;
                        cand  <= key_code;
                        cnt   <= '0;
                    end
                end
                default: begin
                    if (!pressed) begin
                        state    <= IDLE;
                        cnt      <= '0;
                        key_held <= 1'b0;
                    end else if (key_code != cand) begin
                        state    <= DEBOUNCE;
                        cand     <= key_code;
                        cnt      <= '0;
                        key_held <= 1'b0;
                    end else if (term) begin
                        state    <= (state == DEBOUNCE) ? HELD : REPEAT;
                        cnt      <= '0;
                        key_held <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign pop = evt_ready && !empty;

    keypad_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .head      (head_evt),
        .count     (fifo_count),
        .full      (full),
        .empty     (empty)
    );

    assign evt_code   = head_evt.code;
    assign evt_repeat = head_evt.is_repeat;
    assign evt_valid  = !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_keypad_event_queue.sv
// Directed bench for keypad_event_queue with short timing parameters; popped
// events are logged with the cycle they were presented and compared to hand-derived values.
module tb_keypad_event_queue;

    localparam int DB = 8;
    localparam int SC = 16;
    localparam int RD = 40;
    localparam int RR = 10;
    localparam int FD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] key_code;
    logic [3:0] key_row;
    logic [3:0] evt_code;
    logic       evt_repeat;
    logic       evt_valid;
    logic       evt_ready;
    logic       key_held;
    logic       overflow;
    logic [2:0] fifo_count;

    keypad_event_queue #(
        .DEBOUNCE_CYCLES (DB),
        .SCAN_CYCLES     (SC),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .FIFO_DEPTH      (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_code   (key_code),
        .key_row    (key_row),
        .evt_code   (evt_code),
        .evt_repeat (evt_repeat),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .key_held   (key_held),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] code;
        logic       rpt;
        int         at;
    } log_t;
    log_t log_q[$];

    // A handshake seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) log_q.push_back('{evt_code, evt_repeat, cyc});
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code, input int low, input int high);
        key_code = code;
        key_row  = 4'b1011;
        step(low);
        key_row  = 4'hF;
        step(high);
    endtask

    typedef struct {
        logic [3:0] code;
        int         low;
        int         n_ev;
        int         n_rep;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   c0;
        int   nrep;
        logic [3:0] exp_codes[5];

        vecs[0] = '{4'h3, 1,  1, 0};
        vecs[1] = '{4'h9, 40, 2, 1};
        vecs[2] = '{4'hA, 50, 3, 2};
        vecs[3] = '{4'hE, 20, 1, 0};

        rst = 1'b1; key_code = 4'h0; key_row = 4'hF; evt_ready = 1'b0;
        step(2);
        check("reset evt_valid", evt_valid, 0);
        check("reset key_held", key_held, 0);
        check("reset overflow", overflow, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset evt_code", evt_code, 0);
        rst = 1'b0;
        step(30);
        check("idle after reset, no phantom event", fifo_count, 0);

        // Clean press with latency and release timing.
        evt_ready = 1'b1;
        log_q.delete();
        c0 = cyc;
        key_code = 4'h5; key_row = 4'b1011;
        step(12);
        check("clean key_held while pressed", key_held, 1);
        key_row = 4'hF;
        step(15);
        check("clean key_held before release timeout", key_held, 1);
        step(5);
        check("clean key_held after release", key_held, 0);
        step(5);
        check("clean event count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            check("clean code", log_q[0].code, 5);
            check("clean repeat flag", log_q[0].rpt, 0);
            check("clean latency", log_q[0].at - c0, 12);
        end

        // Table of press lengths with expected press/repeat counts.
        foreach (vecs[v]) begin
            log_q.delete();
            press(vecs[v].code, vecs[v].low, 30);
            check($sformatf("vec%0d event count", v), log_q.size(), vecs[v].n_ev);
            nrep = 0;
            foreach (log_q[i]) if (log_q[i].rpt) nrep++;
            check($sformatf("vec%0d repeat count", v), nrep, vecs[v].n_rep);
            if (log_q.size() > 0) begin
                check($sformatf("vec%0d code", v), log_q[0].code, vecs[v].code);
                check($sformatf("vec%0d first is press", v), log_q[0].rpt, 0);
            end
            check($sformatf("vec%0d key_held released", v), key_held, 0);
        end

        // Code bounce: the debounce restarts on the new code.
        log_q.delete();
        c0 = cyc;
        key_code = 4'h5; key_row = 4'b1011;
        step(4);
        key_code = 4'h6;
        step(10);
        key_row = 4'hF;
        step(30);
        check("bounce event count", log_q.size(), 1);
        if (log_q.size() > 0) begin
            check("bounce code", log_q[0].code, 6);
            check("bounce latency", log_q[0].at - c0, 13);
        end

        // Auto-repeat: press then repeats at +40 and every 10 cycles after.
        log_q.delete();
        c0 = cyc;
        press(4'h7, 88, 30);
        check("repeat event count", log_q.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < log_q.size()) begin
                check($sformatf("repeat%0d code", i), log_q[i].code, 7);
                check($sformatf("repeat%0d flag", i), log_q[i].rpt, (i > 0) ? 1 : 0);
                check($sformatf("repeat%0d time", i), log_q[i].at - c0,
                      (i == 0) ? 12 : 12 + RD + RR * (i - 1));
            end
        end

        // Overflow: five events into a four-entry FIFO with no consumer.
        evt_ready = 1'b0;
        log_q.delete();
        for (int k = 1; k <= 5; k++) press(4'(k), 12, 24);
        check("ovf fifo_count", fifo_count, 4);
        check("ovf overflow", overflow, 1);
        check("ovf evt_valid", evt_valid, 1);
        check("ovf head code", evt_code, 1);
        check("ovf head repeat", evt_repeat, 0);
        evt_ready = 1'b1;
        step(8);
        check("ovf drained count", log_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_q.size()) check($sformatf("ovf drain%0d code", i), log_q[i].code, i + 1);
        check("ovf sticky", overflow, 1);
        check("ovf empty", fifo_count, 0);

        // Push and pop in the same cycle while full.
        evt_ready = 1'b0;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(2);
        check("full-pp overflow cleared", overflow, 0);
        for (int k = 1; k <= 4; k++) press(4'(k), 12, 24);
        check("full-pp count before", fifo_count, 4);
        log_q.delete();
        key_code = 4'h8; key_row = 4'b1011;
        step(11);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        check("full-pp count after", fifo_count, 4);
        check("full-pp overflow", overflow, 0);
        check("full-pp new head", evt_code, 2);
        key_row = 4'hF;
        step(24);
        evt_ready = 1'b1;
        step(8);
        exp_codes[0] = 4'h1; exp_codes[1] = 4'h2; exp_codes[2] = 4'h3;
        exp_codes[3] = 4'h4; exp_codes[4] = 4'h8;
        check("full-pp drain count", log_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < log_q.size()) check($sformatf("full-pp drain%0d", i), log_q[i].code, exp_codes[i]);

        // Asynchronous reset in REPEAT, then a fresh debounce.
        evt_ready = 1'b0;
        log_q.delete();
        key_code = 4'hC; key_row = 4'b1011;
        step(90);
        check("mid-repeat key_held", key_held, 1);
        check("mid-repeat overflow", overflow, 1);
        check("mid-repeat count", fifo_count, 4);
        #2;
        rst = 1'b1;
        #1;
        check("async rst evt_valid", evt_valid, 0);
        check("async rst key_held", key_held, 0);
        check("async rst overflow", overflow, 0);
        check("async rst fifo_count", fifo_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(11);
        check("post-rst not yet valid", evt_valid, 0);
        step(1);
        check("post-rst valid", evt_valid, 1);
        check("post-rst code", evt_code, 4'hC);
        check("post-rst repeat", evt_repeat, 0);
        check("post-rst count", fifo_count, 1);
        key_row = 4'hF;
        step(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
